data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//  Responder end of the pipeline's MEM-stage data-memory interface. Accepts the
//  processor's mem_read/mem_write requests, inserts LATENCY wait states, asserts
//  mem_stall to freeze the pipeline meanwhile, then commits the write or returns
//  read_data. Word-addressed RAM; flags misaligned or out-of-range accesses.
// PARAMETERS
//  WORDS      256  number of 32-bit words (power of 2, >=4)
//  LATENCY    2    stall cycles per access (>=1)
//  DATA_WIDTH 32   data bus width
//  ADDR_WIDTH 32   byte-address width
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           asynchronous reset, active-low
//  mem_read    in   1           read request, held while mem_stall=1
//  mem_write   in   1           write request, held while mem_stall=1
//  address     in   ADDR_WIDTH  byte address; word index = address>>2
//  write_data  in   DATA_WIDTH  store data
//  read_data   out  DATA_WIDTH  load data, registered, held until next read done
//  mem_stall   out  1           freeze PC, IF/ID, ID/EX, EX/MEM
//  resp_valid  out  1           one-cycle pulse: access complete this cycle
//  access_fault out 1           one-cycle pulse with resp_valid: bad address
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, cnt=0, read_data=0, mem_stall=0,
//   resp_valid=0, access_fault=0. RAM contents not reset. Reset mid-access aborts;
//   a pending write is discarded.
//  FSM IDLE/BUSY/DONE; latched op, addr, wdata; counter cnt.
//  IDLE: req = mem_read|mem_write. req=1 -> mem_stall=1 combinationally this cycle;
//   latch op/addr/wdata; LATENCY=1 -> DONE, else cnt<=LATENCY-2 -> BUSY.
//   req=0 -> stay, mem_stall=0.
//  BUSY: mem_stall=1; cnt==0 -> DONE else cnt<=cnt-1. Inputs ignored (latched).
//  Edge into DONE: commit. Write: RAM[idx]<=wdata. Read: read_data<=RAM[idx].
//  DONE (one cycle): mem_stall=0, resp_valid=1; pipeline advances at next edge;
//   request inputs in DONE are ignored (no re-accept); next state IDLE.
//  Latency: stall high for exactly LATENCY cycles; done LATENCY cycles after accept.
//  Back-to-back: new req in the IDLE cycle after DONE is accepted normally.
//  mem_read&mem_write both 1: treated as write; read_data unchanged.
//  Fault if addr[1:0]!=0 or (addr>>2)>=WORDS: no write; read sets read_data=0;
//   access_fault=1 in DONE. Fault requests take full LATENCY.
//  Inputs change during BUSY (protocol violation): latched values used.
// TESTING
//  1 rst=0 mid-BUSY of write 0xDEADBEEF@0x10 -> outputs 0, IDLE; read 0x10 returns
//    prior value (write discarded).
//  2 LATENCY=2: write 0x12345678@0x20, then read 0x20 -> stall 2 cycles each,
//    resp_valid on 3rd cycle, read_data=0x12345678.
//  3 Back-to-back: write@0x4 then read@0x4 in next IDLE -> read_data=new value,
//    2 resp_valid pulses, exactly 2*(LATENCY+1) cycles total.
//  4 Read 0x22 (misaligned) and 0x400 (WORDS=256) -> access_fault=1,
//    read_data=0, RAM unchanged.
//  5 mem_read=mem_write=1, wdata 0xA5A5A5A5@0x8 -> RAM[2]=0xA5A5A5A5,
//    read_data unchanged.
//  6 LATENCY=1: read -> mem_stall 1 cycle, resp_valid next cycle; hold request
//    in DONE -> not re-accepted (single resp_valid).

Source files
------------

// File: rtl/data_memory_responder.sv
// Responder for the MEM-stage data-memory port: stalls the pipeline for LATENCY
// cycles per access, then commits the store or returns registered load data.
module data_memory_responder #(
  parameter int WORDS      = 256,
  parameter int LATENCY    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  mem_stall,
  output logic                  resp_valid,
  output logic                  access_fault
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    op_write_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic                    fault_reg;
  logic [DATA_WIDTH-1:0]   read_data_reg;
  logic [DATA_WIDTH-1:0]   ram [WORDS];

  logic                    req;
  logic                    accept;
  logic                    stall_raw;
  logic                    commit;
  logic                    eff_write;
  logic [ADDR_WIDTH-1:0]   eff_addr;
  logic [DATA_WIDTH-1:0]   eff_wdata;
  logic [IDX_W-1:0]        eff_idx;
  logic                    eff_fault;

  assign req = mem_read | mem_write;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_raw  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (req) begin
          stall_raw = 1'b1;
          accept    = 1'b1;
          if (LATENCY == 1) begin
            state_next = DONE;
          end else begin
            state_next = BUSY;
            cnt_next   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        stall_raw = 1'b1;
        if (cnt_reg == '0) state_next = DONE;
        else               cnt_next   = cnt_reg - CNT_W'(1);
      end
      DONE: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stall is combinational from the request in IDLE; keep it quiet while reset is held.
  assign mem_stall    = stall_raw & rst;
  assign access_fault = (state_reg == DONE) & fault_reg;
  assign read_data    = read_data_reg;

  // With LATENCY=1 the commit edge is also the accept edge, so take the live inputs.
  assign eff_write = (state_reg == IDLE) ? mem_write  : op_write_reg;
  assign eff_addr  = (state_reg == IDLE) ? address    : addr_reg;
  assign eff_wdata = (state_reg == IDLE) ? write_data : wdata_reg;
  assign eff_idx   = eff_addr[IDX_W+1:2];
  assign eff_fault = (|eff_addr[1:0]) | (|eff_addr[ADDR_WIDTH-1:IDX_W+2]);
  assign commit    = rst & (state_next == DONE) & (state_reg != DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      op_write_reg  <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      fault_reg     <= 1'b0;
      read_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        op_write_reg <= mem_write;
        addr_reg     <= address;
        wdata_reg    <= write_data;
      end
      if (commit) begin
        fault_reg <= eff_fault;
        if (!eff_write) read_data_reg <= eff_fault ? '0 : ram[eff_idx];
      end
    end
  end

  // RAM contents survive reset; an aborted access never reaches its commit edge.
  always_ff @(posedge clk) begin
    if (commit && eff_write && !eff_fault) ram[eff_idx] <= eff_wdata;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed plus randomized bench for data_memory_responder; an array-based memory
// model predicts faults, load data and the fixed LATENCY+1 cycle handshake.
module tb_data_memory_responder;
  localparam int WORDS = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data;
  logic        mem_stall, resp_valid, access_fault;

  logic        r1 = 1'b0, w1 = 1'b0;
  logic [31:0] a1 = '0, d1 = '0;
  logic [31:0] rd1;
  logic        st1, rv1, af1;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          txn = 0;
  logic [31:0] model [WORDS];
  logic [31:0] exp_rd = '0;
  logic [31:0] exp_rd1 = '0;

  always @(posedge clk) cyc++;

  data_memory_responder #(.WORDS(WORDS), .LATENCY(LAT), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data),
    .mem_stall(mem_stall), .resp_valid(resp_valid), .access_fault(access_fault)
  );

  data_memory_responder #(.WORDS(WORDS), .LATENCY(1), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut1 (
    .clk(clk), .rst(rst), .mem_read(r1), .mem_write(w1),
    .address(a1), .write_data(d1), .read_data(rd1),
    .mem_stall(st1), .resp_valid(rv1), .access_fault(af1)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Starts at posedge+1 with the DUT idle; ends at posedge+1, LAT+1 cycles later.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble);
    bit          fault;
    logic [31:0] r;
    fault = (a[1:0] != 2'b00) || ((a >> 2) >= WORDS);
    mem_read = rd; mem_write = wr; address = a; write_data = d;
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk);
      chk1("stall_busy", mem_stall, 1'b1);
      chk1("resp_busy", resp_valid, 1'b0);
      chk32("rd_hold", read_data, exp_rd);
      @(posedge clk); #1;
      if (scramble && c < LAT - 1) begin
        r = $urandom;
        mem_read = r[0]; mem_write = r[1];
        address = $urandom; write_data = $urandom;
      end
    end
    if (wr) begin
      if (!fault) model[a[9:2]] = d;
    end else begin
      exp_rd = fault ? 32'h0 : model[a[9:2]];
    end
    @(negedge clk);
    chk1("stall_done", mem_stall, 1'b0);
    chk1("resp_done", resp_valid, 1'b1);
    chk1("fault", access_fault, fault);
    chk32("read_data", read_data, exp_rd);
    txn++;
    $display("txn %0d rd=%0b wr=%0b addr=%08h wdata=%08h fault=%0b read_data=%08h",
             txn, rd, wr, a, d, fault, read_data);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // LATENCY=1 instance: request stays held through DONE, then is dropped.
  task automatic access1(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic exp_fault);
    r1 = rd; w1 = wr; a1 = a; d1 = d;
    @(negedge clk);
    chk1("l1_stall", st1, 1'b1);
    chk1("l1_resp_busy", rv1, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("l1_stall_done", st1, 1'b0);
    chk1("l1_resp", rv1, 1'b1);
    chk1("l1_fault", af1, exp_fault);
    chk32("l1_read_data", rd1, exp_rd1);
    txn++;
    $display("txn %0d L1 rd=%0b wr=%0b addr=%08h wdata=%08h read_data=%08h",
             txn, rd, wr, a, d, rd1);
    @(posedge clk); #1;
    r1 = 1'b0; w1 = 1'b0;
    @(negedge clk);
    chk1("l1_no_reaccept", rv1, 1'b0);
    chk1("l1_idle_stall", st1, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    int          t0;
    bit          op_rd, op_wr;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_stall", mem_stall, 1'b0);
    chk1("rst_resp", resp_valid, 1'b0);
    chk1("rst_fault", access_fault, 1'b0);
    chk32("rst_rd", read_data, 32'h0);
    chk1("rst_l1_stall", st1, 1'b0);
    chk32("rst_l1_rd", rd1, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < WORDS; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

    // write then read back with two stall cycles each
    access(1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0);
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    chk32("t2_read", read_data, 32'h12345678);

    // back-to-back write/read of the same word
    t0 = cyc;
    access(1'b0, 1'b1, 32'h4, 32'h0BADCAFE, 1'b0);
    access(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    chk32("t3_cycles", 32'(cyc - t0), 32'(2 * (LAT + 1)));
    chk32("t3_read", read_data, 32'h0BADCAFE);

    // faulting accesses leave RAM alone and zero the load data
    access(1'b1, 1'b0, 32'h22, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h400, 32'h0, 1'b0);
    chk32("t4_rd_zero", read_data, 32'h0);
    access(1'b0, 1'b1, 32'h23, 32'hFFFFFFFF, 1'b0);
    access(1'b0, 1'b1, 32'h420, 32'hFFFFFFFF, 1'b0);
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    chk32("t4_ram_kept", read_data, 32'h12345678);

    // read+write together acts as a write
    access(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 1'b0);
    chk32("t5_rd_unchanged", read_data, 32'h12345678);
    access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
    chk32("t5_ram", read_data, 32'hA5A5A5A5);

    // reset in the middle of a write aborts it
    mem_write = 1'b1; address = 32'h10; write_data = 32'hDEADBEEF;
    @(posedge clk); #2;
    rst = 1'b0; mem_write = 1'b0;
    #1;
    chk1("t1_stall", mem_stall, 1'b0);
    chk1("t1_resp", resp_valid, 1'b0);
    chk1("t1_fault", access_fault, 1'b0);
    chk32("t1_rd", read_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_rd = 32'h0;
    @(negedge clk);
    chk1("t1_idle", mem_stall, 1'b0);
    chk1("t1_noresp", resp_valid, 1'b0);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    chk1("t1_discarded", read_data !== 32'hDEADBEEF, 1'b1);

    // randomized mix, including faults and inputs disturbed while busy
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'($urandom_range(0, WORDS - 1) * 4 + $urandom_range(1, 3));
      else if (r == 1) a = 32'(WORDS * 4 + $urandom_range(0, 4000) * 4);
      else             a = 32'($urandom_range(0, WORDS - 1) * 4);
      r = $urandom_range(0, 2);
      op_rd = (r != 1);
      op_wr = (r != 0);
      access(op_rd, op_wr, a, $urandom, ($urandom_range(0, 3) == 0));
    end

    // LATENCY=1 instance
    access1(1'b0, 1'b1, 32'h0C, 32'hCAFEF00D, 1'b0);
    exp_rd1 = 32'hCAFEF00D;
    access1(1'b1, 1'b0, 32'h0C, 32'h0, 1'b0);
    exp_rd1 = 32'h0;
    access1(1'b1, 1'b0, 32'h401, 32'h0, 1'b1);
    access1(1'b0, 1'b1, 32'h10, 32'h00001111, 1'b0);
    access1(1'b1, 1'b1, 32'h10, 32'h00002222, 1'b0);
    exp_rd1 = 32'h00002222;
    access1(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
